// File: rtl/priority_bit_iterator.sv
// priority_bit_iterator
//   Takes one DATA_W-bit word per accept and emits each set bit of it as a
//   separate output beat, LSB-first (dir_i = 0) or MSB-first (dir_i = 1).
//   An all-zero word produces a single beat flagged with zero_o.
//
// Ports
//   clk_i, arst_i        clock, asynchronous active-high reset
//   data_i, dir_i        word and iteration order, sampled on accept
//   data_val_i           upstream valid
//   data_ready_o         block can take a word (combinational from data_ready_i)
//   onehot_o, idx_o      current bit as one-hot mask and binary index
//   last_o, zero_o       final beat of the word / word was all zeros
//   data_val_o           output beat valid
//   data_ready_i         downstream accepts the beat
//
// state | meaning
// IDLE  | no word held, ready for a new one
// BUSY  | presenting beats of the held word from rem_q
module priority_bit_iterator #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              dir_i,
  input  logic              data_val_i,
  output logic              data_ready_o,
  output logic [DATA_W-1:0] onehot_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              last_o,
  output logic              zero_o,
  output logic              data_val_o,
  input  logic              data_ready_i
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic              dir_q, dir_d;
  logic              zero_q, zero_d;

  logic [DATA_W-1:0] rem_rev;
  logic [DATA_W-1:0] sel_lsb;
  logic [DATA_W-1:0] sel_msb;
  logic [DATA_W-1:0] onehot;
  logic [IDX_W-1:0]  idx;
  logic              last_sel;
  logic              busy;
  logic              fire;
  logic              accept;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = v[DATA_W-1-i];
    end
    return r;
  endfunction

  // Lowest set bit via two's-complement isolation; MSB-first reuses the same
  // trick on the mirrored vector.
  always_comb begin
    rem_rev  = bit_rev(rem_q);
    sel_lsb  = rem_q & (-rem_q);
    sel_msb  = bit_rev(rem_rev & (-rem_rev));
    onehot   = dir_q ? sel_msb : sel_lsb;
    last_sel = ((rem_q & ~onehot) == '0);
    idx      = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (onehot[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
  end

  assign busy         = (state_q == BUSY);
  assign data_val_o   = busy;
  assign onehot_o     = busy ? onehot : '0;
  assign idx_o        = busy ? idx : '0;
  assign last_o       = busy & last_sel;
  assign zero_o       = busy & zero_q;

  // Ready during the last beat lets the next word follow with no bubble.
  assign data_ready_o = ~busy | (last_sel & data_ready_i);

  assign fire   = busy & data_ready_i;
  assign accept = data_val_i & data_ready_o;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    zero_d  = zero_q;
    if (fire) begin
      if (last_sel) begin
        state_d = IDLE;
        rem_d   = '0;
      end else begin
        rem_d   = rem_q & ~onehot;
      end
    end
    // A new word overrides the retirement of the previous last beat.
    if (accept) begin
      state_d = BUSY;
      rem_d   = data_i;
      dir_d   = dir_i;
      zero_d  = (data_i == '0);
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_priority_bit_iterator.sv
// Testbench for priority_bit_iterator: directed table plus multi-cycle
// sequences on a 16-bit instance, and randomized scoreboard runs on both a
// 16-bit and a 5-bit instance.
module tb_priority_bit_iterator;

  logic clk = 1'b0;
  logic arst_i = 1'b1;
  always #5 clk = ~clk;

  // 16-bit instance
  logic [15:0] d16;
  logic        dir16, vi16, ro16, ri16, last16, zero16, vo16;
  logic [15:0] oh16;
  logic [3:0]  idx16;

  // 5-bit instance
  logic [4:0]  d5;
  logic        dir5, vi5, ro5, ri5, last5, zero5, vo5;
  logic [4:0]  oh5;
  logic [2:0]  idx5;

  priority_bit_iterator #(.DATA_W(16)) u16 (
    .clk_i(clk), .arst_i(arst_i), .data_i(d16), .dir_i(dir16),
    .data_val_i(vi16), .data_ready_o(ro16), .onehot_o(oh16), .idx_o(idx16),
    .last_o(last16), .zero_o(zero16), .data_val_o(vo16), .data_ready_i(ri16)
  );

  priority_bit_iterator #(.DATA_W(5)) u5 (
    .clk_i(clk), .arst_i(arst_i), .data_i(d5), .dir_i(dir5),
    .data_val_i(vi5), .data_ready_o(ro5), .onehot_o(oh5), .idx_o(idx5),
    .last_o(last5), .zero_o(zero5), .data_val_o(vo5), .data_ready_i(ri5)
  );

  int n_pass  = 0;
  int n_total = 0;
  int fire16  = 0;

  always @(posedge clk) begin
    if (!arst_i && vo16 && ri16) fire16 <= fire16 + 1;
  end

  task automatic check(input string nm, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic set_ins(input int sel, input logic [15:0] d, input logic dir,
                         input logic vi, input logic ri);
    if (sel == 0) begin
      d16 = d; dir16 = dir; vi16 = vi; ri16 = ri;
    end else begin
      d5 = d[4:0]; dir5 = dir; vi5 = vi; ri5 = ri;
    end
  endtask

  task automatic get_outs(input int sel, output logic [15:0] oh, output logic [3:0] idx,
                          output logic last, output logic zero,
                          output logic vo, output logic ro);
    if (sel == 0) begin
      oh = oh16; idx = idx16; last = last16; zero = zero16; vo = vo16; ro = ro16;
    end else begin
      oh = {11'b0, oh5}; idx = {1'b0, idx5}; last = last5; zero = zero5; vo = vo5; ro = ro5;
    end
  endtask

  typedef struct {
    bit          first;
    logic [15:0] data;
    bit          dir;
    logic [15:0] oh;
    logic [3:0]  idx;
    bit          last;
    bit          zero;
  } vec_t;

  typedef struct {
    logic [15:0] oh;
    logic [3:0]  idx;
    bit          last;
    bit          zero;
  } beat_t;

  // Reference: a word becomes the list of its set-bit positions, walked in
  // the requested order; a zero word is one flagged empty beat.
  task automatic word_beats(input logic [15:0] w, input bit dir, input int width,
                            inout beat_t q[$]);
    int pos[$];
    beat_t b;
    for (int i = 0; i < width; i++) if (w[i]) pos.push_back(i);
    if (dir) pos.reverse();
    if (pos.size() == 0) begin
      b.oh = '0; b.idx = '0; b.last = 1; b.zero = 1;
      q.push_back(b);
    end else begin
      for (int k = 0; k < pos.size(); k++) begin
        b.oh   = 16'(1) << pos[k];
        b.idx  = 4'(pos[k]);
        b.last = (k == pos.size() - 1);
        b.zero = 0;
        q.push_back(b);
      end
    end
  endtask

  task automatic rand_run(input int sel, input int width, input int cycles);
    beat_t       q[$];
    beat_t       b;
    logic [15:0] word, mask, oh;
    logic [3:0]  idx;
    logic        last, zero, vo, ro, ri, dir;
    bit          offering, exp_ro;
    string       tag;
    tag = (sel == 0) ? "r16" : "r5";
    mask = 16'((32'd1 << width) - 1);
    offering = 0; word = '0; dir = 0;
    for (int c = 0; c < cycles + 60; c++) begin
      @(negedge clk);
      if (!offering && c < cycles && ($urandom_range(1, 0) == 1)) begin
        word = ($urandom_range(7, 0) == 0) ? 16'h0 : (16'($urandom) & mask);
        dir = 1'($urandom_range(1, 0));
        offering = 1;
      end
      ri = (c >= cycles) ? 1'b1 : ($urandom_range(3, 0) != 0);
      set_ins(sel, word, dir, offering, ri);
      #1;
      get_outs(sel, oh, idx, last, zero, vo, ro);
      check({tag, "_val"}, vo, (q.size() != 0));
      exp_ro = (q.size() == 0) ? 1'b1 : (ri && q[0].last);
      check({tag, "_ready"}, ro, exp_ro);
      if (!vo) check({tag, "_idle_outs"}, {oh, idx, last, zero}, 0);
      if (vo && ri && q.size() != 0) begin
        b = q.pop_front();
        check({tag, "_onehot"}, oh, b.oh);
        check({tag, "_idx"}, idx, b.idx);
        check({tag, "_last"}, last, b.last);
        check({tag, "_zero"}, zero, b.zero);
      end
      if (offering && ro) begin
        word_beats(word, dir, width, q);
        offering = 0;
      end
    end
    check({tag, "_drained"}, q.size(), 0);
    set_ins(sel, '0, 0, 0, 0);
  endtask

  vec_t tab[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int base;
    set_ins(0, '0, 0, 0, 0);
    set_ins(1, '0, 0, 0, 0);

    // reset state
    repeat (2) @(negedge clk);
    check("rst_val", vo16, 0);
    check("rst_ready", ro16, 1);
    check("rst_outs", {oh16, idx16, last16, zero16}, 0);
    arst_i = 1'b0;

    // table: LSB-first, MSB-first and a zero word, continuous ready
    tab = '{
      '{1, 16'h8421, 0, 16'h0001, 4'd0,  0, 0},
      '{0, 16'h8421, 0, 16'h0020, 4'd5,  0, 0},
      '{0, 16'h8421, 0, 16'h0400, 4'd10, 0, 0},
      '{0, 16'h8421, 0, 16'h8000, 4'd15, 1, 0},
      '{1, 16'h8421, 1, 16'h8000, 4'd15, 0, 0},
      '{0, 16'h8421, 1, 16'h0400, 4'd10, 0, 0},
      '{0, 16'h8421, 1, 16'h0020, 4'd5,  0, 0},
      '{0, 16'h8421, 1, 16'h0001, 4'd0,  1, 0},
      '{1, 16'h0000, 0, 16'h0000, 4'd0,  1, 1}
    };
    foreach (tab[i]) begin
      v = tab[i];
      if (v.first) begin
        @(negedge clk);
        set_ins(0, v.data, v.dir, 1, 1);
        @(negedge clk);
        set_ins(0, '0, 0, 0, 1);
      end else begin
        @(negedge clk);
      end
      #1;
      check($sformatf("tab%0d_val", i), vo16, 1);
      check($sformatf("tab%0d_onehot", i), oh16, v.oh);
      check($sformatf("tab%0d_idx", i), idx16, v.idx);
      check($sformatf("tab%0d_last", i), last16, v.last);
      check($sformatf("tab%0d_zero", i), zero16, v.zero);
    end
    @(negedge clk);
    check("tab_end_val", vo16, 0);

    // asynchronous reset mid-word
    set_ins(0, 16'h00F0, 0, 1, 1);
    @(negedge clk);
    set_ins(0, '0, 0, 0, 1);
    @(negedge clk);
    #1;
    check("ar_pre_onehot", oh16, 16'h0020);
    #2 arst_i = 1'b1;
    #1;
    check("ar_val", vo16, 0);
    check("ar_ready", ro16, 1);
    check("ar_onehot", oh16, 0);
    @(negedge clk);
    arst_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("ar_no_stale", vo16, 0);
    end

    // backpressure: hold first beat for three cycles
    base = fire16;
    set_ins(0, 16'h0006, 0, 1, 0);
    @(negedge clk);
    set_ins(0, '0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_hold_onehot", oh16, 16'h0002);
      check("bp_hold_idx", idx16, 1);
      check("bp_hold_last", last16, 0);
      @(negedge clk);
    end
    ri16 = 1'b1;
    #1;
    check("bp_rel_onehot", oh16, 16'h0002);
    @(negedge clk);
    #1;
    check("bp_2nd_onehot", oh16, 16'h0004);
    check("bp_2nd_idx", idx16, 2);
    check("bp_2nd_last", last16, 1);
    @(negedge clk);
    check("bp_done_val", vo16, 0);
    check("bp_fires", fire16 - base, 2);

    // back-to-back words, zero bubble
    set_ins(0, 16'h0003, 0, 1, 1);
    @(negedge clk);
    set_ins(0, 16'h0100, 0, 1, 1);
    #1;
    check("b2b_b0_onehot", oh16, 16'h0001);
    check("b2b_b0_ready", ro16, 0);
    @(negedge clk);
    #1;
    check("b2b_b1_onehot", oh16, 16'h0002);
    check("b2b_b1_last", last16, 1);
    check("b2b_b1_ready", ro16, 1);
    @(negedge clk);
    set_ins(0, '0, 0, 0, 1);
    #1;
    check("b2b_b2_val", vo16, 1);
    check("b2b_b2_onehot", oh16, 16'h0100);
    check("b2b_b2_idx", idx16, 8);
    check("b2b_b2_last", last16, 1);
    @(negedge clk);
    check("b2b_end_val", vo16, 0);
    set_ins(0, '0, 0, 0, 0);

    // randomized scoreboard runs
    @(negedge clk);
    arst_i = 1'b1;
    @(negedge clk);
    arst_i = 1'b0;
    rand_run(0, 16, 2000);
    rand_run(1, 5, 2000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
